// File: rtl/db_pkg.sv
// Shared state encodings for the debounce channels and the event arbiter.
// No logic in this file.
// No flow control in this file.
package db_pkg;

   typedef enum logic [1:0] {
      e_zero  = 2'd0,
      e_wait1 = 2'd1,
      e_one   = 2'd2,
      e_wait0 = 2'd3
   } t_debounce_state;

   typedef enum logic {
      e_idle  = 1'b0,
      e_offer = 1'b1
   } t_arb_state;

endpackage

// File: rtl/db_channel.sv
// Early-detect debounce for one switch: 2-FF sync, then a lockout FSM clocked by a shared strobe.
// Latency: 3 clk from a raw switch edge to o_sw_debounced / o_rise (2 sync + 1 FSM).
// No backpressure: o_rise is a 1-cycle pulse that the parent must capture.
module db_channel
   import db_pkg::*;
#(
   parameter int LOCKOUT_STROBES = 20
)
(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_sw,
   input  logic i_strobe,
   output logic o_rise,
   output logic o_sw_debounced
);

   localparam int LKW = $clog2(LOCKOUT_STROBES + 1);
   localparam logic [LKW-1:0] LK_INIT = LKW'(LOCKOUT_STROBES);
   localparam logic [LKW-1:0] LK_LAST = LKW'(1);

   logic            sw_m;
   logic            sw_s;
   t_debounce_state state;
   t_debounce_state state_nxt;
   logic [LKW-1:0]  lk;
   logic [LKW-1:0]  lk_nxt;
   logic            rise_nxt;

   // Two-flop synchronizer for the raw asynchronous switch input.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sw_m <= 1'b0;
         sw_s <= 1'b0;
      end else begin
         sw_m <= i_sw;
         sw_s <= sw_m;
      end
   end

   // Next state: act on the first edge, then ignore the input until the lockout expires.
   always_comb begin
      state_nxt = state;
      lk_nxt    = lk;
      rise_nxt  = 1'b0;
      case (state)
         e_zero: begin
            if (sw_s) begin
               state_nxt = e_wait1;
               lk_nxt    = LK_INIT;
               rise_nxt  = 1'b1;
            end
         end
         e_wait1: begin
            if (i_strobe) begin
               lk_nxt = lk - LK_LAST;
               if (lk == LK_LAST) state_nxt = e_one;
            end
         end
         e_one: begin
            if (!sw_s) begin
               state_nxt = e_wait0;
               lk_nxt    = LK_INIT;
            end
         end
         e_wait0: begin
            if (i_strobe) begin
               lk_nxt = lk - LK_LAST;
               if (lk == LK_LAST) state_nxt = e_zero;
            end
         end
         default: state_nxt = e_zero;
      endcase
   end

   // State, lockout counter and rise pulse registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state  <= e_zero;
         lk     <= '0;
         o_rise <= 1'b0;
      end else begin
         state  <= state_nxt;
         lk     <= lk_nxt;
         o_rise <= rise_nxt;
      end
   end

   // The debounced level covers the lockout after a press, so bounce cannot drop it.
   assign o_sw_debounced = (state == e_wait1) || (state == e_one);

endmodule

// File: rtl/db_event_arbiter.sv
// N-channel debouncer with one shared lockout prescaler and round-robin press-event queue.
// Latency: event offered 2 clk after the channel rise pulse (pend flop, then offer register).
// Backpressure: offer held stable until i_evt_ready; a further press on a pending channel sets o_overrun.
module db_event_arbiter
   import db_pkg::*;
#(
   parameter int N_CH            = 4,
   parameter int STROBE_PERIOD   = 100_000,
   parameter int LOCKOUT_STROBES = 20
)
(
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [N_CH-1:0]         i_sw,
   output logic [N_CH-1:0]         o_sw_debounced,
   output logic                    o_evt_valid,
   output logic [$clog2(N_CH)-1:0] o_evt_ch,
   input  logic                    i_evt_ready,
   output logic [N_CH-1:0]         o_overrun,
   input  logic                    i_overrun_clr
);

   localparam int CW = $clog2(N_CH);
   localparam int PW = (STROBE_PERIOD > 1) ? $clog2(STROBE_PERIOD) : 1;

   logic [PW-1:0]   presc;
   logic            strobe;
   logic [N_CH-1:0] rise;
   logic [N_CH-1:0] pend;
   logic [N_CH-1:0] clr;
   logic [N_CH-1:0] ovr_set;
   logic            hs;
   t_arb_state      arb_state;
   t_arb_state      arb_nxt;
   logic [CW-1:0]   ptr;
   logic [CW-1:0]   ptr_nxt;
   logic [CW-1:0]   ch_nxt;
   logic            found;
   logic [CW:0]     scan_idx;

   assign strobe = (presc == PW'(STROBE_PERIOD - 1));

   // Free-running prescaler shared by every channel's lockout counter.
   always_ff @(posedge i_clk) begin
      if (i_rst)       presc <= '0;
      else if (strobe) presc <= '0;
      else             presc <= presc + PW'(1);
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      db_channel #(
         .LOCKOUT_STROBES(LOCKOUT_STROBES)
      ) u_ch (
         .i_clk         (i_clk),
         .i_rst         (i_rst),
         .i_sw          (i_sw[g]),
         .i_strobe      (strobe),
         .o_rise        (rise[g]),
         .o_sw_debounced(o_sw_debounced[g])
      );
   end

   assign o_evt_valid = (arb_state == e_offer);
   assign hs          = o_evt_valid && i_evt_ready;

   // One-hot clear for the channel whose event is being accepted this cycle.
   always_comb begin
      clr = '0;
      if (hs) clr[o_evt_ch] = 1'b1;
   end

   // A rise on a bit that stays pending is a lost press; a rise that coincides with its own clear is not.
   assign ovr_set = rise & pend & ~clr;

   // Pending bits and sticky overrun flags; a new overrun beats a simultaneous clear.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pend      <= '0;
         o_overrun <= '0;
      end else begin
         pend      <= rise | (pend & ~clr);
         o_overrun <= i_overrun_clr ? ovr_set : (o_overrun | ovr_set);
      end
   end

   // Arbiter next state: pick the first pending channel at or above ptr, wrapping to 0.
   always_comb begin
      arb_nxt  = arb_state;
      ptr_nxt  = ptr;
      ch_nxt   = o_evt_ch;
      found    = 1'b0;
      scan_idx = '0;
      case (arb_state)
         e_idle: begin
            if (|pend) begin
               for (int i = 0; i < N_CH; i++) begin
                  scan_idx = {1'b0, ptr} + (CW + 1)'(i);
                  if (scan_idx >= (CW + 1)'(N_CH)) scan_idx = scan_idx - (CW + 1)'(N_CH);
                  if (!found && pend[scan_idx[CW-1:0]]) begin
                     found  = 1'b1;
                     ch_nxt = scan_idx[CW-1:0];
                  end
               end
               arb_nxt = e_offer;
            end
         end
         e_offer: begin
            if (i_evt_ready) begin
               arb_nxt = e_idle;
               ptr_nxt = (o_evt_ch == CW'(N_CH - 1)) ? '0 : o_evt_ch + CW'(1);
            end
         end
         default: arb_nxt = e_idle;
      endcase
   end

   // Arbiter state, round-robin pointer and offered channel registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         arb_state <= e_idle;
         ptr       <= '0;
         o_evt_ch  <= '0;
      end else begin
         arb_state <= arb_nxt;
         ptr       <= ptr_nxt;
         o_evt_ch  <= ch_nxt;
      end
   end

endmodule

// File: tb/tb_db_event_arbiter.sv
// Bench for db_event_arbiter: round-robin vector table plus directed debounce/backpressure/reset sequences.
// Expected grant channels are queued when presses are driven and popped by a handshake monitor.
// Inputs change 1 ns after posedge; the monitor samples on negedge.
module tb_db_event_arbiter;

   localparam int N_CH = 4;
   localparam int SP   = 4;
   localparam int LS   = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] sw;
   logic [3:0] deb;
   logic       vld;
   logic [1:0] ch;
   logic       rdy;
   logic [3:0] ovr;
   logic       oclr;

   always #5 clk = ~clk;

   db_event_arbiter #(
      .N_CH(N_CH),
      .STROBE_PERIOD(SP),
      .LOCKOUT_STROBES(LS)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_sw(sw),
      .o_sw_debounced(deb),
      .o_evt_valid(vld),
      .o_evt_ch(ch),
      .i_evt_ready(rdy),
      .o_overrun(ovr),
      .i_overrun_clr(oclr)
   );

   int   n_chk    = 0;
   int   n_pass   = 0;
   int   n_grants = 0;
   int   exp_q[$];
   logic prev_hs  = 1'b0;

   typedef struct {
      int         pre_ch;
      logic [3:0] mask;
      int         n;
      int         order[4];
   } arb_vec_t;

   arb_vec_t vecs[4];

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Handshake monitor: every accepted event must match the scoreboard head.
   always @(negedge clk) begin
      if (rst) begin
         prev_hs <= 1'b0;
      end else begin
         if (prev_hs) check("idle_after_grant", int'(vld), 0);
         if (vld && rdy) begin
            if (exp_q.size() == 0) check("unexpected_grant_ch", int'(ch), -1);
            else                   check("grant_ch", int'(ch), exp_q.pop_front());
            n_grants++;
         end
         prev_hs <= vld && rdy;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name);
      for (int k = 0; k < 20 && !vld; k++) tick(1);
      check(name, int'(vld), 1);
   endtask

   task automatic wait_drain(input string name);
      for (int k = 0; k < 80 && exp_q.size() != 0; k++) tick(1);
      tick(2);
      check(name, exp_q.size(), 0);
   endtask

   task automatic settle();
      sw = '0;
      tick(40);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int g0;
      logic drop;
      logic stable;

      vecs[0] = '{pre_ch: 3, mask: 4'b1011, n: 3, order: '{0, 1, 3, 0}};
      vecs[1] = '{pre_ch: 1, mask: 4'b1011, n: 3, order: '{3, 0, 1, 0}};
      vecs[2] = '{pre_ch: 0, mask: 4'b0101, n: 2, order: '{2, 0, 0, 0}};
      vecs[3] = '{pre_ch: 2, mask: 4'b1111, n: 4, order: '{3, 0, 1, 2}};

      rst = 1'b1; sw = '0; rdy = 1'b0; oclr = 1'b0;
      tick(3);
      check("rst_deb", int'(deb), 0);
      check("rst_valid", int'(vld), 0);
      check("rst_ch", int'(ch), 0);
      check("rst_ovr", int'(ovr), 0);
      rst = 1'b0;
      tick(7);

      // Clean press on ch2.
      sw[2] = 1'b1; exp_q.push_back(2);
      tick(2);
      check("t1_deb_before", int'(deb[2]), 0);
      tick(1);
      check("t1_deb_rise", int'(deb[2]), 1);
      wait_valid("t1_valid");
      check("t1_ch", int'(ch), 2);
      rdy = 1'b1;
      tick(1);
      check("t1_valid_drop", int'(vld), 0);
      wait_drain("t1_drain");
      settle();

      // Bounce on ch0 with the consumer always ready.
      g0 = n_grants; drop = 1'b0;
      exp_q.push_back(0);
      for (int k = 0; k < 6; k++) begin
         sw[0] = ((k % 2) == 0);
         tick(1);
         if (k >= 2 && !deb[0]) drop = 1'b1;
      end
      sw[0] = 1'b1;
      for (int k = 0; k < 15; k++) begin
         tick(1);
         if (!deb[0]) drop = 1'b1;
      end
      check("t2_no_drop", int'(drop), 0);
      wait_drain("t2_drain");
      tick(20);
      check("t2_one_event", n_grants - g0, 1);
      settle();

      // Round-robin table: a lone press on pre_ch positions the pointer, then the mask presses at once.
      for (int v = 0; v < 4; v++) begin
         rdy = 1'b1;
         sw = 4'b0001 << vecs[v].pre_ch;
         exp_q.push_back(vecs[v].pre_ch);
         wait_drain("vec_pre_drain");
         settle();
         sw = vecs[v].mask;
         for (int j = 0; j < vecs[v].n; j++) exp_q.push_back(vecs[v].order[j]);
         tick(3);
         check("vec_deb", int'(deb), int'(vecs[v].mask));
         wait_drain("vec_drain");
         settle();
         check("vec_deb_released", int'(deb), 0);
      end

      // Backpressure on ch1 with a lost second press.
      rdy = 1'b0; g0 = n_grants; stable = 1'b1;
      sw[1] = 1'b1; exp_q.push_back(1);
      wait_valid("t4_valid");
      for (int c = 0; c < 50; c++) begin
         if (c == 0)  sw[1] = 1'b0;
         if (c == 40) sw[1] = 1'b1;
         tick(1);
         if (!vld || ch != 2'd1) stable = 1'b0;
      end
      check("t4_stable", int'(stable), 1);
      check("t4_ovr", int'(ovr), 4'b0010);
      oclr = 1'b1;
      tick(1);
      oclr = 1'b0;
      check("t4_ovr_clr", int'(ovr), 0);
      rdy = 1'b1;
      wait_drain("t4_drain");
      tick(20);
      check("t4_grants", n_grants - g0, 1);
      settle();

      // Reset while ch0 is locked out and its event is offered.
      rdy = 1'b0;
      sw[0] = 1'b1; exp_q.push_back(0);
      wait_valid("t5_valid");
      check("t5_deb_pre", int'(deb[0]), 1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("t5_rst_deb", int'(deb), 0);
      check("t5_rst_valid", int'(vld), 0);
      check("t5_rst_ch", int'(ch), 0);
      check("t5_rst_ovr", int'(ovr), 0);
      exp_q.delete();
      exp_q.push_back(0);
      tick(2);
      check("t5_deb_before", int'(deb[0]), 0);
      tick(1);
      check("t5_deb_rise", int'(deb[0]), 1);
      rdy = 1'b1;
      wait_drain("t5_drain");
      settle();

      // Rise on ch2 in the same cycle its previous event is accepted.
      rdy = 1'b0; g0 = n_grants;
      sw[2] = 1'b1; exp_q.push_back(2);
      wait_valid("t6_valid");
      check("t6_ch", int'(ch), 2);
      sw[2] = 1'b0;
      tick(40);
      sw[3] = 1'b1; exp_q.push_back(3);
      tick(1);
      sw[2] = 1'b1; exp_q.push_back(2);
      tick(3);
      check("t6_deb2", int'(deb[2]), 1);
      rdy = 1'b1;
      tick(1);
      rdy = 1'b0;
      tick(1);
      check("t6_ovr", int'(ovr), 0);
      wait_valid("t6_next_valid");
      check("t6_next_ch", int'(ch), 3);
      rdy = 1'b1;
      wait_drain("t6_drain");
      tick(10);
      check("t6_grants", n_grants - g0, 3);
      check("t6_ovr_end", int'(ovr), 0);
      settle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
